conv_arbiter: RTL and testbench
===============================

# conv_arbiter

Round-robin arbiter and sequencer that shares one `circuitocinco` 3-bit→4-bit code converter between two requesters. Captures the winning code, registers the converted word, and returns it on a valid/ready response channel tagged with the requester ID. Sits between the input requesters and any downstream consumer of converted codes.

## Interface

Parameters:
- `CNT_W`, default 8: width of per-requester grant counters (used only with `CONV_STATS_EN`).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  2  bit i: requester i presents a code.
- `req_code`  in  2×3 (packed `[1:0][2:0]`)  code from requester i.
- `req_ready`  out  2  one-hot accept strobe; a request is taken in a cycle where `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  1  converted result available.
- `rsp_id`  out  1  requester index the result belongs to.
- `rsp_data`  out  4  converted word {y3,y2,y1,y0}.
- `rsp_ready`  in  1  downstream accepts the result.
- `busy`  out  1  high whenever state ≠ IDLE.
- `gnt_cnt`  out  2×CNT_W  grants per requester (see Configuration).

## Operation

- FSM states: IDLE, CONV, RESP.
- IDLE: if no `req_valid`, stay. Otherwise pick winner:
  - only one valid → that one;
  - both valid → requester `rr_ptr`.
  - Assert `req_ready[winner]` combinationally this cycle. Latch `code_q <= req_code[winner]` and `id_q <= winner`. Set `rr_ptr <= ~winner`. Go to CONV.
- CONV: converter is driven from `code_q`. Register its output into `rsp_data`, `rsp_id <= id_q`. Set `rsp_valid <= 1`. Go to RESP.
- RESP: hold `rsp_valid`, `rsp_data` and `rsp_id` stable. On `rsp_ready`, clear `rsp_valid` and go to IDLE.
- `req_ready` is 0 in CONV and RESP.
- Conversion map (code→data), fixed by the converter: 0→5, 1→3, 2→1, 3→1, 4→3, 5→5, 6→7, 7→9. `rsp_data[0]` is always 1.
- A requester may drop `req_valid` while not granted; this has no effect. `req_code` is sampled only in the accept cycle.
- Reset values: state IDLE, `rr_ptr` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_id` 0, `busy` 0, `req_ready` 0, `gnt_cnt` 0.
- Reset asserted mid-operation aborts any conversion or pending response. No response is emitted for it.

## Timing

- Accept at cycle T (IDLE): `rsp_valid` is high from T+2.
- Handshake at cycle H (RESP): IDLE at H+1. The next accept is possible at H+1.
- Max throughput: one conversion per 3 cycles when `rsp_ready` is held high.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,… starting with 0 after reset.
- Back-pressure: with `rsp_ready` low, the block stalls in RESP indefinitely. No request is accepted meanwhile.

## Configuration

- `CONV_STATS_EN` defined:
  - `gnt_cnt[i]` increments on each accept of requester i.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - It is cleared by `rst`.
- Not defined: counter logic is absent, and `gnt_cnt` is tied to 0. The port list is identical in both builds.

## Structure

- Package `conv_pkg`:
  - state enum `conv_state_t` {IDLE, CONV, RESP};
  - `N_REQ = 2`;
  - `CODE_W = 3`;
  - `DATA_W = 4`.
- One sub-module: the existing `circuitocinco` converter. It is instantiated once, with inputs from `code_q` and outputs feeding the `rsp_data` register. The arbiter contains no conversion logic of its own.

## Test plan

- Reset then idle:
  - all outputs are 0 after `rst`;
  - with `req_valid`=00 held for 10 cycles, `busy` stays 0 and `rsp_valid` stays 0.
- Single request:
  - stimulus: requester 1, code 6, `rsp_ready`=1;
  - required: `req_ready`=10 at T, `rsp_valid`=1 with `rsp_data`=7 and `rsp_id`=1 at T+2, `busy` 0 at T+3.
- Full map sweep:
  - stimulus: requester 0 issues codes 0..7 back-to-back;
  - required: responses 5,3,1,1,3,5,7,9 in order, one every 3 cycles.
- Contention:
  - stimulus: both requesters valid continuously (codes 7 and 0) for 6 grants;
  - required: `rsp_id` sequence 0,1,0,1,0,1 with data 9,5,9,5,9,5.
- Back-pressure and mid-op reset:
  - hold `rsp_ready`=0 for 5 cycles in RESP; `rsp_data`/`rsp_id` stay stable and `req_ready` stays 00;
  - then pulse `rst`; `rsp_valid`=0 next cycle and no stale response ever appears.
- Stats (with `CONV_STATS_EN`, `CNT_W`=2):
  - stimulus: 5 grants to requester 0;
  - required: `gnt_cnt[0]`=3 (saturated) and `gnt_cnt[1]`=0.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and sizes for the conv_arbiter slice.
//   conv_state_t : sequencer states (IDLE, CONV, RESP)
//   N_REQ        : number of requesters sharing the converter
//   CODE_W       : width of an input code
//   DATA_W       : width of a converted word
package conv_pkg;

  localparam int N_REQ  = 2;
  localparam int CODE_W = 3;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } conv_state_t;

endpackage

// File: rtl/circuitocinco.sv
// circuitocinco: fixed 3-bit to 4-bit code converter (purely combinational).
//   code : input code {x2,x1,x0}
//   data : converted word {y3,y2,y1,y0}; y0 is always 1
// Map: 0->5, 1->3, 2->1, 3->1, 4->3, 5->5, 6->7, 7->9.
module circuitocinco
  import conv_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = 4'd5;
    case (code)
      3'd0: data = 4'd5;
      3'd1: data = 4'd3;
      3'd2: data = 4'd1;
      3'd3: data = 4'd1;
      3'd4: data = 4'd3;
      3'd5: data = 4'd5;
      3'd6: data = 4'd7;
      3'd7: data = 4'd9;
      default: data = 4'd5;
    endcase
  end

endmodule

// File: rtl/conv_arbiter.sv
// conv_arbiter: round-robin arbiter/sequencer sharing one circuitocinco
// converter between two requesters; result returned on a valid/ready channel
// tagged with the requester index.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/code  : per-requester request and 3-bit code
//   req_ready       : one-hot accept strobe (combinational, IDLE only)
//   rsp_valid/id/data/ready : response channel
//   busy            : high whenever the sequencer is not IDLE
//   gnt_cnt         : saturating per-requester grant counters
// Optional feature macro: CONV_STATS_EN enables gnt_cnt; otherwise it is 0.
module conv_arbiter
  import conv_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    req_valid,
  input  logic [N_REQ-1:0][CODE_W-1:0]        req_code,
  output logic [N_REQ-1:0]                    req_ready,
  output logic                                rsp_valid,
  output logic                                rsp_id,
  output logic [DATA_W-1:0]                   rsp_data,
  input  logic                                rsp_ready,
  output logic                                busy,
  output logic [N_REQ-1:0][CNT_W-1:0]         gnt_cnt
);

  conv_state_t         state_reg, state_next;
  logic                rr_ptr_reg;
  logic [CODE_W-1:0]   code_q;
  logic                id_q;
  logic                winner;
  logic                accept;
  logic [DATA_W-1:0]   conv_data;

  circuitocinco u_conv (
    .code (code_q),
    .data (conv_data)
  );

  // With both valid the pointer decides; otherwise the single valid one wins.
  always_comb begin
    winner = (req_valid == 2'b11) ? rr_ptr_reg : req_valid[1];
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          req_ready[winner] = 1'b1;
          accept            = 1'b1;
          state_next        = CONV;
        end
      end
      CONV: state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= 1'b0;
      code_q     <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        code_q     <= req_code[winner];
        id_q       <= winner;
        rr_ptr_reg <= ~winner;
      end
      if (state_reg == CONV) begin
        rsp_data  <= conv_data;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (state_reg == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_reg != IDLE);

`ifdef CONV_STATS_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst)
        cnt_reg <= '0;
      else if (req_valid[gi] && req_ready[gi] && (cnt_reg != {CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + 1'b1;
    end
    assign gnt_cnt[gi] = cnt_reg;
  end
`else
  assign gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_arbiter.sv
// tb_conv_arbiter: directed self-checking bench for conv_arbiter.
module tb_conv_arbiter;
  import conv_pkg::*;

  localparam int CNT_W = 2;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][CODE_W-1:0] req_code;
  logic [N_REQ-1:0]             req_ready;
  logic                         rsp_valid;
  logic                         rsp_id;
  logic [DATA_W-1:0]            rsp_data;
  logic                         rsp_ready;
  logic                         busy;
  logic [N_REQ-1:0][CNT_W-1:0]  gnt_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  conv_arbiter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .gnt_cnt   (gnt_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction starting in IDLE with rsp_ready=1.
  task automatic transact(input logic [1:0] v, input logic [2:0] c0, input logic [2:0] c1,
                          input logic exp_id, input logic [3:0] exp_data, input string tag);
    req_valid = v;
    req_code[0] = c0;
    req_code[1] = c1;
    rsp_ready = 1'b1;
    #1;
    check({tag, " req_ready"}, 32'(req_ready), exp_id ? 32'h2 : 32'h1);
    tick();
    check({tag, " conv rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, " conv req_ready"}, 32'(req_ready), 32'h0);
    tick();
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'h1);
    check({tag, " rsp_id"}, 32'(rsp_id), 32'(exp_id));
    check({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
    tick();
    check({tag, " busy after"}, 32'(busy), 32'h0);
  endtask

  logic [3:0] map_tbl [8] = '{4'd5, 4'd3, 4'd1, 4'd1, 4'd3, 4'd5, 4'd7, 4'd9};

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_code = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("reset rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset rsp_data", 32'(rsp_data), 32'h0);
    check("reset rsp_id", 32'(rsp_id), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset req_ready", 32'(req_ready), 32'h0);
    check("reset gnt_cnt", 32'(gnt_cnt), 32'h0);
    rst = 1'b0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle busy", 32'(busy), 32'h0);
      check("idle rsp_valid", 32'(rsp_valid), 32'h0);
    end

    // Single request: requester 1, code 6 -> 7
    transact(2'b10, 3'd0, 3'd6, 1'b1, 4'd7, "single");

    // Map sweep, requester 0, back-to-back
    for (int i = 0; i < 8; i++)
      transact(2'b01, 3'(i), 3'd0, 1'b0, map_tbl[i], $sformatf("sweep%0d", i));

    // Contention after reset: starts with 0, alternates
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      transact(2'b11, 3'd7, 3'd0, 1'(i % 2), (i % 2) ? 4'd5 : 4'd9, $sformatf("contend%0d", i));

    // Back-pressure: rr_ptr now 0, so requester 0 (code 3 -> 1) wins
    req_valid = 2'b11;
    req_code[0] = 3'd3;
    req_code[1] = 3'd6;
    rsp_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp rsp_data", 32'(rsp_data), 32'h1);
      check("bp rsp_id", 32'(rsp_id), 32'h0);
      check("bp req_ready", 32'(req_ready), 32'h0);
      tick();
    end
    // Mid-op reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    check("midrst rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst busy", 32'(busy), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst no stale", 32'(rsp_valid), 32'h0);
    end

    // Stats: 5 grants to requester 0
    for (int i = 0; i < 5; i++)
      transact(2'b01, 3'd5, 3'd0, 1'b0, 4'd5, $sformatf("stats%0d", i));
`ifdef CONV_STATS_EN
    check("gnt_cnt0 sat", 32'(gnt_cnt[0]), 32'h3);
    check("gnt_cnt1", 32'(gnt_cnt[1]), 32'h0);
`else
    check("gnt_cnt disabled", 32'(gnt_cnt), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
